addsub_chunked: RTL

Multi-cycle, parametrised adder/subtractor for the cpu1 datapath. It processes a WIDTH-bit operation CHUNK bits per clock, so wide ALU operations run through a narrow carry chain. It supports four modes (ADD, ADC, SUB, SBB) and produces carry, overflow, zero and negative flags. A start/busy/done handshake toward the control unit governs each operation.

---
 rtl/addsub_chunked.sv | 125 ++++++++++++
 1 files changed

// File: rtl/addsub_chunked.sv
// addsub_chunked: multi-cycle ADD/ADC/SUB/SBB that runs a WIDTH-bit operation through a CHUNK-bit carry chain
module addsub_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             ci,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             co,
    output logic             vo,
    output logic             zo,
    output logic             no
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, res_q, res_d;
    logic             c_q, c_d, nz_q, nz_d, done_q, done_d;
    logic             co_q, co_d, vo_q, vo_d, zo_q, zo_d, no_q, no_d;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] r_shift;
    logic             c_msb;

    // one CHUNK-bit add per cycle; the new chunk enters the result from the top
    always_comb begin
        sum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
        r_shift = (r_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        c_msb   = sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    end

    // FSM next state: capture operands in IDLE, walk the chunks in RUN, publish on the last one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        nz_d    = nz_q;
        done_d  = 1'b0;
        res_d   = res_q;
        co_d    = co_q;
        vo_d    = vo_q;
        zo_d    = zo_q;
        no_d    = no_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                a_d     = ai;
                b_d     = op[1] ? ~bi : bi;
                c_d     = op[0] ? ci : op[1];
                cnt_d   = '0;
                nz_d    = 1'b0;
            end
        end else begin
            a_d   = a_q >> CHUNK;
            b_d   = b_q >> CHUNK;
            c_d   = sum[CHUNK];
            r_d   = r_shift;
            nz_d  = nz_q | (|sum[CHUNK-1:0]);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                res_d   = r_shift;
                co_d    = sum[CHUNK];
                vo_d    = c_msb ^ sum[CHUNK];
                zo_d    = ~nz_d;
                no_d    = sum[CHUNK-1];
            end
        end
    end

    // state registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            nz_q    <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
            vo_q    <= 1'b0;
            zo_q    <= 1'b0;
            no_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            nz_q    <= nz_d;
            done_q  <= done_d;
            res_q   <= res_d;
            co_q    <= co_d;
            vo_q    <= vo_d;
            zo_q    <= zo_d;
            no_q    <= no_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = done_q;
    assign res  = res_q;
    assign co   = co_q;
    assign vo   = vo_q;
    assign zo   = zo_q;
    assign no   = no_q;
endmodule
